router_out_reader: RTL and testbench

- Egress consumer for one router output port.
- Watches the port FIFO's valid flag, drains one packet at a time through r_enb, and parses each packet into header, payload and parity byte.
- Streams payload bytes to a downstream sink, checks parity, and keeps packet and error counters.
- Reads within the router's 30-cycle soft-reset window; if the router soft-resets the port anyway, it aborts the packet cleanly.
- One instance sits on each of the three output ports.

---
 rtl/router_out_reader.sv | 138 +++++++++++++
 tb/tb_router_out_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_reader.sv
// Egress reader for one router output port: drains the port FIFO one packet at a time,
// streams payload bytes to the sink, checks parity and keeps packet/error counters.
module router_out_reader #(
  parameter int unsigned READ_DELAY = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  input  logic             s_rst,
  input  logic             sink_rdy,
  output logic             r_enb,
  output logic [7:0]       byte_out,
  output logic             byte_vld,
  output logic [1:0]       pkt_addr,
  output logic [5:0]       pkt_len,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic             pkt_abort,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned DLY_W = 5;
  localparam int unsigned LEN_W = 6;
  // First read lands READ_DELAY cycles after vld_out rises; 0 and 1 both skip WAIT.
  localparam logic             SKIP_WAIT = (READ_DELAY <= 1);
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'((READ_DELAY > 1) ? READ_DELAY - 1 : 0);

  typedef enum logic [2:0] {IDLE, WAIT, HDR, BODY, PAR, DONE} state_t;

  state_t           state, state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [LEN_W-1:0] issued, rcvd;
  logic [7:0]       parity;
  logic             rd_pend;
  logic             abort_c, hdr_cap_c, par_chk_c, par_bad_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign par_bad_c = (data_out != parity) || (pkt_len == '0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_c) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (vld_out) state_nxt = SKIP_WAIT ? HDR : WAIT;
        WAIT: begin
          if (!vld_out)                              state_nxt = IDLE;
          else if (dly_cnt + DLY_W'(1) == DLY_LAST)  state_nxt = HDR;
        end
        HDR:  if (hdr_cap_c) state_nxt = (data_out[7:2] == '0) ? PAR : BODY;
        BODY: if (byte_vld && (rcvd + LEN_W'(1) == pkt_len)) state_nxt = PAR;
        PAR:  if (par_chk_c) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Read strobe and byte strobe follow s_rst combinationally so an abort takes effect in-cycle.
  always_comb begin
    r_enb     = 1'b0;
    byte_vld  = 1'b0;
    abort_c   = 1'b0;
    hdr_cap_c = 1'b0;
    par_chk_c = 1'b0;
    if (s_rst) begin
      abort_c = (state != IDLE) && (state != DONE);
    end else begin
      case (state)
        HDR: begin
          r_enb     = vld_out & ~rd_pend;
          hdr_cap_c = rd_pend;
        end
        BODY: begin
          r_enb    = vld_out & sink_rdy & (issued != pkt_len);
          byte_vld = rd_pend;
        end
        PAR: begin
          r_enb     = vld_out & ~rd_pend;
          par_chk_c = rd_pend;
        end
        default: ;
      endcase
    end
    byte_out = byte_vld ? data_out : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_pend   <= 1'b0;
      dly_cnt   <= '0;
      issued    <= '0;
      rcvd      <= '0;
      parity    <= '0;
      pkt_addr  <= '0;
      pkt_len   <= '0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_abort <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      rd_pend   <= r_enb;
      pkt_done  <= par_chk_c;
      pkt_err   <= par_chk_c & par_bad_c;
      pkt_abort <= abort_c;
      dly_cnt   <= (state == WAIT && vld_out) ? dly_cnt + DLY_W'(1) : '0;
      if (par_chk_c && !par_bad_c) pkt_cnt <= sat_inc(pkt_cnt);
      if (abort_c || (par_chk_c && par_bad_c)) err_cnt <= sat_inc(err_cnt);
      if (hdr_cap_c) begin
        pkt_len  <= data_out[7:2];
        pkt_addr <= data_out[1:0];
        parity   <= data_out;
        issued   <= '0;
        rcvd     <= '0;
      end else begin
        if (state == BODY && r_enb) issued <= issued + LEN_W'(1);
        if (byte_vld) begin
          parity <= parity ^ data_out;
          rcvd   <= rcvd + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_router_out_reader.sv
// Self-checking bench for router_out_reader: FIFO model feeding random packets,
// reference expectations derived from the packet format.
module tb_router_out_reader;

  localparam int RD   = 5;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          rstn, s_rst, sink_rdy, vld_out;
  logic [7:0]    data_out = 8'h00;
  logic          r_enb, byte_vld, pkt_done, pkt_err, pkt_abort;
  logic [7:0]    byte_out;
  logic [1:0]    pkt_addr;
  logic [5:0]    pkt_len;
  logic [CW-1:0] pkt_cnt, err_cnt;

  router_out_reader #(.READ_DELAY(RD), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .vld_out(vld_out), .data_out(data_out), .s_rst(s_rst),
    .sink_rdy(sink_rdy), .r_enb(r_enb), .byte_out(byte_out), .byte_vld(byte_vld),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .pkt_abort(pkt_abort), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Port FIFO model: registered read data, flushed by s_rst.
  logic [7:0] mem [0:1023];
  int         wr_ptr = 0, rd_ptr = 0;
  logic       vld_en = 1'b0;
  assign vld_out = vld_en && (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (s_rst) rd_ptr <= wr_ptr;
    else if (r_enb && wr_ptr != rd_ptr) begin
      data_out <= mem[rd_ptr % 1024];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Observation log
  int         cyc = 0, viol = 0, abort_n = 0;
  int         ren_cyc[$];
  logic [7:0] got_bytes[$];
  logic       done_err[$];
  logic       prev_ren = 1'b0, prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (r_enb === 1'b1) begin
      ren_cyc.push_back(cyc);
      if (!vld_out || s_rst) viol++;
    end
    if (byte_vld === 1'b1) begin
      got_bytes.push_back(byte_out);
      if (!(prev_ren && prev_rdy)) viol++;
    end
    if (pkt_done === 1'b1) done_err.push_back(pkt_err);
    if (pkt_err === 1'b1 && pkt_done !== 1'b1) viol++;
    if (pkt_abort === 1'b1) abort_n++;
    prev_ren = (r_enb === 1'b1);
    prev_rdy = sink_rdy;
    cyc++;
  end

  int         tests = 0, fails = 0;
  int         exp_pkt = 0, exp_err = 0;
  logic [7:0] pay [0:63];

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input string name, input logic [7:0] hdr, input logic [7:0] corrupt,
                         input int rdy_pct, input int glitch, input bit srst_done, input bit rand_pay);
    int         len, b0, d0, a0, r0, t0, budget, pi;
    logic [7:0] par;
    logic [7:0] exp_q[$];
    bit         exp_bad;
    logic [6:0] pat;
    pat = 7'b1011001;
    vld_en = 1'b0;
    len = int'(hdr[7:2]);
    par = hdr;
    push_byte(hdr);
    for (int i = 0; i < len; i++) begin
      if (rand_pay) pay[i] = 8'($urandom);
      exp_q.push_back(pay[i]);
      par = par ^ pay[i];
      push_byte(pay[i]);
    end
    push_byte(par ^ corrupt);
    exp_bad = (corrupt != 8'h00) || (len == 0);
    b0 = got_bytes.size(); d0 = done_err.size(); a0 = abort_n; r0 = ren_cyc.size();
    if (glitch > 0) begin
      vld_en = 1'b1;
      repeat (glitch) tick();
      vld_en = 1'b0;
      repeat (3) tick();
      tests++;
      if (ren_cyc.size() != r0) begin
        fails++; $display("FAIL %s early_read: %0d reads during short vld, required 0", name, ren_cyc.size() - r0);
      end
    end
    sink_rdy = 1'b1;
    t0 = cyc;
    vld_en = 1'b1;
    budget = 0; pi = 0;
    while (done_err.size() == d0 && budget < 3000) begin
      tick();
      s_rst = srst_done && pkt_done;
      if (rdy_pct < 0) begin
        sink_rdy = pat[6 - (pi % 7)];
        pi++;
      end else begin
        sink_rdy = ($urandom_range(99) < rdy_pct);
        if (rdy_pct < 100 && ren_cyc.size() > r0) vld_en = ($urandom_range(7) != 0);
      end
      budget++;
    end
    repeat (3) tick();
    s_rst = 1'b0; sink_rdy = 1'b1; vld_en = 1'b0;
    if (exp_bad) exp_err = sat(exp_err);
    else         exp_pkt = sat(exp_pkt);

    tests++;
    if (ren_cyc.size() <= r0) begin
      fails++; $display("FAIL %s first_read: no read observed, required at cycle %0d", name, t0 + RD);
    end else if (ren_cyc[r0] != t0 + RD) begin
      fails++; $display("FAIL %s first_read: cycle %0d, required %0d", name, ren_cyc[r0], t0 + RD);
    end
    tests++;
    if (done_err.size() != d0 + 1) begin
      fails++; $display("FAIL %s done_count: %0d pulses, required 1", name, done_err.size() - d0);
    end
    if (done_err.size() > d0) begin
      tests++;
      if (done_err[d0] !== exp_bad) begin
        fails++; $display("FAIL %s pkt_err: %b, required %b", name, done_err[d0], exp_bad);
      end
    end
    tests++;
    if (pkt_addr !== hdr[1:0] || pkt_len !== hdr[7:2]) begin
      fails++; $display("FAIL %s header: addr %0d len %0d, required addr %0d len %0d",
                        name, pkt_addr, pkt_len, hdr[1:0], hdr[7:2]);
    end
    tests++;
    if (got_bytes.size() - b0 != len) begin
      fails++; $display("FAIL %s byte_count: %0d, required %0d", name, got_bytes.size() - b0, len);
    end
    for (int i = 0; i < len; i++) begin
      if (b0 + i < got_bytes.size()) begin
        tests++;
        if (got_bytes[b0 + i] !== exp_q[i]) begin
          fails++; $display("FAIL %s byte%0d: %h, required %h", name, i, got_bytes[b0 + i], exp_q[i]);
        end
      end
    end
    tests++;
    if (abort_n != a0) begin
      fails++; $display("FAIL %s abort: %0d pulses, required 0", name, abort_n - a0);
    end
    tests++;
    if (pkt_cnt !== CW'(exp_pkt) || err_cnt !== CW'(exp_err)) begin
      fails++; $display("FAIL %s counters: pkt %0d err %0d, required pkt %0d err %0d",
                        name, pkt_cnt, err_cnt, exp_pkt, exp_err);
    end
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL %s protocol: %0d violations, required 0", name, viol);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_rst = 1'b1; sink_rdy = 1'b1; vld_en = 1'b0;
    repeat (3) tick();
    tests++;
    if ({r_enb, byte_vld, byte_out, pkt_addr, pkt_len, pkt_done, pkt_err, pkt_abort, pkt_cnt, err_cnt} !== '0) begin
      fails++; $display("FAIL reset_outputs: r_enb %b byte_vld %b byte %h addr %0d len %0d done %b err %b abort %b pkt %0d errc %0d, required all 0",
                        r_enb, byte_vld, byte_out, pkt_addr, pkt_len, pkt_done, pkt_err, pkt_abort, pkt_cnt, err_cnt);
    end
    rstn = 1'b1; s_rst = 1'b0;
    repeat (2) tick();
    tests++;
    if (pkt_abort !== 1'b0 || err_cnt !== '0) begin
      fails++; $display("FAIL reset_priority: abort %b err_cnt %0d, required 0 0", pkt_abort, err_cnt);
    end
  endtask

  task automatic test_basic();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_pkt("basic", 8'h0D, 8'h00, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_parity();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_pkt("bad_parity", 8'h0D, 8'h0D, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_delay();
    run_pkt("delay_glitch", 8'h09, 8'h00, 100, RD - 1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_pkt("backpressure", 8'h12, 8'h00, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_zero_len();
    run_pkt("zero_len", 8'h02, 8'h00, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_srst_done();
    run_pkt("srst_at_done", 8'h0B, 8'h00, 100, 0, 1'b1, 1'b1);
  endtask

  task automatic test_srst_idle();
    int a0;
    a0 = abort_n;
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    repeat (2) tick();
    tests++;
    if (abort_n != a0 || err_cnt !== CW'(exp_err)) begin
      fails++; $display("FAIL srst_idle: aborts %0d err_cnt %0d, required 0 %0d", abort_n - a0, err_cnt, exp_err);
    end
  endtask

  task automatic test_abort();
    int         b0, d0, a0, budget;
    logic [7:0] par;
    logic [7:0] exp_q[$];
    vld_en = 1'b0;
    par = 8'h15;
    push_byte(8'h15);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'($urandom));
      par = par ^ exp_q[i];
      push_byte(exp_q[i]);
    end
    push_byte(par);
    b0 = got_bytes.size(); d0 = done_err.size(); a0 = abort_n;
    sink_rdy = 1'b1; vld_en = 1'b1;
    budget = 0;
    while (got_bytes.size() - b0 < 3 && budget < 200) begin
      tick();
      budget++;
    end
    tests++;
    if (got_bytes.size() - b0 != 3) begin
      fails++; $display("FAIL abort_setup: %0d bytes before s_rst, required 3", got_bytes.size() - b0);
    end
    s_rst = 1'b1;
    #1;
    tests++;
    if (r_enb !== 1'b0 || byte_vld !== 1'b0) begin
      fails++; $display("FAIL abort_same_cycle: r_enb %b byte_vld %b, required 0 0", r_enb, byte_vld);
    end
    tick();
    s_rst = 1'b0;
    exp_err = sat(exp_err);
    tests++;
    if (pkt_abort !== 1'b1 || err_cnt !== CW'(exp_err)) begin
      fails++; $display("FAIL abort_pulse: abort %b err_cnt %0d, required 1 %0d", pkt_abort, err_cnt, exp_err);
    end
    repeat (4) tick();
    vld_en = 1'b0;
    tests++;
    if (got_bytes.size() - b0 != 3 || done_err.size() != d0 || abort_n != a0 + 1) begin
      fails++; $display("FAIL abort_after: bytes %0d dones %0d aborts %0d, required 3 0 1",
                        got_bytes.size() - b0, done_err.size() - d0, abort_n - a0);
    end
    for (int i = 0; i < 3; i++) begin
      if (b0 + i < got_bytes.size()) begin
        tests++;
        if (got_bytes[b0 + i] !== exp_q[i]) begin
          fails++; $display("FAIL abort_byte%0d: %h, required %h", i, got_bytes[b0 + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] hdr, cor;
    for (int n = 0; n < 10; n++) begin
      hdr = {6'($urandom_range(12)), 2'($urandom)};
      cor = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      run_pkt("random", hdr, cor, int'($urandom_range(100, 30)), int'($urandom_range(RD - 1)),
              ($urandom_range(9) == 0), 1'b1);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 10 && exp_pkt < CMAX; n++)
      run_pkt("sat_fill_pkt", {6'($urandom_range(4)), 2'($urandom)} | 8'h04, 8'h00, 100, 0, 1'b0, 1'b1);
    run_pkt("sat_pkt", 8'h0E, 8'h00, 100, 0, 1'b0, 1'b1);
    tests++;
    if (pkt_cnt !== 3'b111) begin
      fails++; $display("FAIL pkt_cnt_saturate: %0d, required 7", pkt_cnt);
    end
    for (int n = 0; n < 10 && exp_err < CMAX; n++)
      run_pkt("sat_fill_err", 8'h01, 8'h00, 100, 0, 1'b0, 1'b1);
    run_pkt("sat_err", 8'h03, 8'h00, 100, 0, 1'b0, 1'b1);
    tests++;
    if (err_cnt !== 3'b111) begin
      fails++; $display("FAIL err_cnt_saturate: %0d, required 7", err_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bad_parity();
    test_read_delay();
    test_backpressure();
    test_abort();
    test_srst_idle();
    test_zero_len();
    test_srst_done();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
